// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: run/step/halt/breakpoint sequencer and executed-cycle counter for the MIPS core
module mips_run_ctrl #(
    parameter int RST_CYC  = 4,
    parameter bit AUTO_RUN = 1'b0,
    parameter int PC_W     = 8,
    parameter int CNT_W    = 16
) (
    input  logic             Clk_O,
    input  logic             Reset,
    input  logic             Run_Req,
    input  logic             Step_Req,
    input  logic             Halt_Req,
    input  logic             Clr_Cnt,
    input  logic             Bp_En,
    input  logic [PC_W-1:0]  Bp_Addr,
    input  logic [PC_W-1:0]  PC,
    output logic             Cpu_Rst,
    output logic             Cpu_En,
    output logic [1:0]       State,
    output logic             Bp_Hit,
    output logic             Step_Done,
    output logic [CNT_W-1:0] Cycle_Cnt
);
    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_HALT = 2'd1,
        S_RUN  = 2'd2,
        S_STEP = 2'd3
    } state_t;

    localparam int              IC_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(RST_CYC - 1);

    state_t           r_state;
    logic [IC_W-1:0]  r_init_cnt;
    logic             r_cpu_rst;
    logic             r_skip;
    logic             r_bp_hit;
    logic             r_step_done;
    logic [CNT_W-1:0] r_cyc;
    logic             w_match;
    logic             w_en;

    // breakpoint only matters in RUN and is masked on the first cycle after a resume
    always_comb begin
        w_match = (r_state == S_RUN) && Bp_En && (PC == Bp_Addr) && !r_skip;
        w_en    = ((r_state == S_RUN) && !w_match) || (r_state == S_STEP);
    end

    // sequencer: reset hold, halt/step/run transitions, breakpoint stop and step completion pulse
    always_ff @(posedge Clk_O or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_INIT;
            r_init_cnt  <= '0;
            r_cpu_rst   <= 1'b1;
            r_skip      <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_step_done <= 1'b0;
        end else begin
            r_step_done <= (r_state == S_STEP);
            case (r_state)
                S_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == IC_LAST) begin
                        r_state   <= AUTO_RUN ? S_RUN : S_HALT;
                        r_cpu_rst <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (!Halt_Req && Step_Req) begin
                        r_state  <= S_STEP;
                        r_bp_hit <= 1'b0;
                    end else if (!Halt_Req && Run_Req) begin
                        r_state  <= S_RUN;
                        r_skip   <= 1'b1;
                        r_bp_hit <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_skip <= 1'b0;
                    if (w_match) begin
                        r_state  <= S_HALT;
                        r_bp_hit <= 1'b1;
                    end else if (Halt_Req) begin
                        r_state <= S_HALT;
                    end
                end
                S_STEP: r_state <= S_HALT;
            endcase
        end
    end

    // saturating count of enabled core cycles; clear wins over increment
    always_ff @(posedge Clk_O or negedge Reset) begin
        if (!Reset) r_cyc <= '0;
        else if (Clr_Cnt) r_cyc <= '0;
        else if (w_en && (r_cyc != '1)) r_cyc <= r_cyc + 1'b1;
    end

    assign Cpu_Rst   = r_cpu_rst;
    assign Cpu_En    = w_en;
    assign State     = r_state;
    assign Bp_Hit    = r_bp_hit;
    assign Step_Done = r_step_done;
    assign Cycle_Cnt = r_cyc;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: directed and random stimulus against a cycle-level reference of the run controller
module tb_mips_run_ctrl;
    localparam int RST_CYC = 4;
    localparam bit AUTO_RUN = 1'b0;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0, clr_cnt = 1'b0, bp_en = 1'b0;
    logic [7:0] bp_addr = '0, pc = '0;
    logic cpu_rst, cpu_en, bp_hit, step_done;
    logic [1:0] state;
    logic [CNT_W-1:0] cycle_cnt;

    bit g_rst = 1'b0, g_bp_en = 1'b0;
    logic [7:0] g_bp_addr = '0;
    int n_chk = 0, n_fail = 0;
    int m_st = 0, m_ic = 0, m_cyc = 0;
    bit m_skip = 1'b0, m_bp = 1'b0, m_sd = 1'b0, m_en = 1'b0, m_rst = 1'b1;

    mips_run_ctrl #(.RST_CYC(RST_CYC), .AUTO_RUN(AUTO_RUN), .PC_W(8), .CNT_W(CNT_W)) dut (
        .Clk_O(clk), .Reset(rst_n), .Run_Req(run_req), .Step_Req(step_req), .Halt_Req(halt_req),
        .Clr_Cnt(clr_cnt), .Bp_En(bp_en), .Bp_Addr(bp_addr), .PC(pc), .Cpu_Rst(cpu_rst),
        .Cpu_En(cpu_en), .State(state), .Bp_Hit(bp_hit), .Step_Done(step_done), .Cycle_Cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_advance(input bit r, input bit s, input bit h, input bit c);
        bit match;
        match = (m_st == 2) && bp_en && (pc == bp_addr) && !m_skip;
        m_cyc = c ? 0 : (m_en ? ((m_cyc < CNT_MAX) ? m_cyc + 1 : CNT_MAX) : m_cyc);
        m_sd = (m_st == 3);
        if (m_st == 0) begin
            if (m_ic == RST_CYC - 1) m_st = AUTO_RUN ? 2 : 1;
            m_ic++;
        end else if (m_st == 1) begin
            if (!h && s) begin m_st = 3; m_bp = 1'b0; end
            else if (!h && r) begin m_st = 2; m_skip = 1'b1; m_bp = 1'b0; end
        end else if (m_st == 2) begin
            m_skip = 1'b0;
            if (match) begin m_st = 1; m_bp = 1'b1; end
            else if (h) m_st = 1;
        end else m_st = 1;
    endtask

    // one clock cycle: advance the core PC, drive inputs, compare outputs, step the reference
    task automatic tick(input bit r = 1'b0, input bit s = 1'b0, input bit h = 1'b0, input bit c = 1'b0);
        @(negedge clk);
        pc = m_rst ? 8'd0 : (m_en ? pc + 8'd1 : pc);
        rst_n = g_rst; bp_en = g_bp_en; bp_addr = g_bp_addr;
        run_req = r; step_req = s; halt_req = h; clr_cnt = c;
        if (!rst_n) begin
            m_st = 0; m_ic = 0; m_cyc = 0; m_skip = 0; m_bp = 0; m_sd = 0;
        end
        #1;
        m_rst = (m_st == 0);
        m_en = ((m_st == 2) && !(bp_en && pc == bp_addr && !m_skip)) || (m_st == 3);
        check("state", state, m_st);
        check("cpu_rst", cpu_rst, m_rst);
        check("cpu_en", cpu_en, m_en);
        check("bp_hit", bp_hit, m_bp);
        check("step_done", step_done, m_sd);
        check("cycle_cnt", cycle_cnt, m_cyc);
        if (rst_n) model_advance(r, s, h, c);
    endtask

    initial begin
        int n, w;
        logic [7:0] pc0;
        repeat (3) tick();
        g_rst = 1'b1;
        n = 0;
        repeat (6) begin
            tick();
            if (cpu_rst) n++;
        end
        check("init_len", n, 4);
        check("init_state", state, 1);
        check("init_en", cpu_en, 0);
        check("init_cnt", cycle_cnt, 0);

        tick(.r(1'b1));
        w = 0;
        while (pc != 8'd8 && w < 40) begin tick(); w++; end
        check("run_wait", w < 40, 1);
        tick(.h(1'b1));
        tick();
        check("run10_cnt", cycle_cnt, 10);
        check("run10_state", state, 1);
        check("run10_pc", pc, 10);

        g_rst = 1'b0;
        tick();
        g_rst = 1'b1;
        w = 0;
        while (state != 2'd1 && w < 20) begin tick(); w++; end
        g_bp_en = 1'b1;
        g_bp_addr = 8'h0C;
        tick(.r(1'b1));
        tick();
        w = 0;
        while (state != 2'd1 && w < 40) begin
            if (pc == 8'h0C) check("bp_en_drop", cpu_en, 0);
            tick();
            w++;
        end
        check("bp_state", state, 1);
        check("bp_hit", bp_hit, 1);
        check("bp_pc", pc, 8'h0C);
        check("bp_cnt", cycle_cnt, 12);
        repeat (2) tick();
        check("bp_pc_hold", pc, 8'h0C);
        tick(.r(1'b1));
        repeat (3) tick();
        check("bp_resume_pc", pc, 8'h0E);
        check("bp_resume_hit", bp_hit, 0);
        tick(.h(1'b1));
        tick();
        check("bp_resume_halt", state, 1);
        g_bp_en = 1'b0;

        tick(.c(1'b1));
        pc0 = pc;
        n = 0;
        repeat (3) begin
            tick(.s(1'b1));
            repeat (3) begin
                tick();
                if (step_done) n++;
            end
        end
        check("step_pc", pc, pc0 + 8'd3);
        check("step_done_cnt", n, 3);
        check("step_cnt", cycle_cnt, 3);

        tick(.r(1'b1));
        repeat (2) tick();
        tick(.h(1'b1), .r(1'b1));
        tick();
        check("halt_over_run", state, 1);
        tick(.s(1'b1), .r(1'b1));
        tick();
        check("step_over_run", state, 3);
        tick();

        tick(.c(1'b1));
        tick(.r(1'b1));
        repeat (21) tick();
        check("sat_cnt", cycle_cnt, 15);
        tick(.c(1'b1));
        tick();
        check("clr_run", cycle_cnt, 0);
        tick();
        check("clr_resume", cycle_cnt, 1);
        g_rst = 1'b0;
        tick();
        check("rst_mid_state", state, 0);
        check("rst_mid_cpu_rst", cpu_rst, 1);
        g_rst = 1'b1;

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) g_bp_en = !g_bp_en;
            if ($urandom_range(0, 9) == 0) g_bp_addr = pc + 8'($urandom_range(1, 6));
            g_rst = ($urandom_range(0, 199) != 0);
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 14) == 0, $urandom_range(0, 29) == 0);
        end
        g_rst = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
